// File: rtl/pos_pkg.sv
// Shared definitions for the pos position encoder/decoder pair: generator
// state encoding and the single 7-bit pattern table both sides agree on.
package pos_pkg;

  // PG_ prefix keeps these clear of the decoder's s0..s15 state names.
  typedef enum logic [2:0] {
    PG_IDLE  = 3'd0,
    PG_PRE   = 3'd1,
    PG_DRIVE = 3'd2,
    PG_GUARD = 3'd3,
    PG_DONE  = 3'd4
  } pg_state_t;

  // Bit order is {a,b,c,d,e,f,g}, a in the MSB.
  localparam logic [6:0] POS_PAT0 = 7'b1110010;
  localparam logic [6:0] POS_PAT1 = 7'b0110000;
  localparam logic [6:0] POS_PAT2 = 7'b1101101;
  localparam logic [6:0] POS_PAT3 = 7'b1111001;

  function automatic logic [6:0] pos_pattern(input logic [1:0] code);
    logic [6:0] pat;
    case (code)
      2'd0:    pat = POS_PAT0;
      2'd1:    pat = POS_PAT1;
      2'd2:    pat = POS_PAT2;
      default: pat = POS_PAT3;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/pos_pattern_rom.sv
// Combinational 2-bit position code to 7-bit segment pattern lookup.
module pos_pattern_rom
  import pos_pkg::*;
(
  input  logic [1:0] i_code,
  output logic [6:0] o_pattern
);

  assign o_pattern = pos_pattern(i_code);

endmodule

// File: rtl/pos_pattern_gen.sv
// Framed pattern transmitter: on an accepted start it drives PRE (zero),
// DRIVE (pattern of the latched code), GUARD (zero), then a one-cycle DONE.
//
// Handshake: start is a single-cycle request sampled only in IDLE; while busy
// is high or done is high, start and pos_in are ignored. No ready signal.
module pos_pattern_gen
  import pos_pkg::*;
#(
  parameter int unsigned HOLD  = 4,
  parameter int unsigned GUARD = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] pos_in,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       e,
  output logic       f,
  output logic       g,
  output logic       busy,
  output logic       done
);

  localparam logic [7:0] HOLD_LAST  = 8'(HOLD - 1);
  localparam logic [7:0] GUARD_LAST = 8'(GUARD - 1);

  pg_state_t  r_state, w_state_nxt;
  logic [7:0] r_cnt, w_cnt_nxt;
  logic [1:0] r_code, w_code_nxt;
  logic [6:0] r_seg, w_seg_nxt;
  logic       r_busy, w_busy_nxt;
  logic       r_done, w_done_nxt;
  logic [6:0] w_pattern;

  // DRIVE is only ever entered from PRE, so r_code is already latched there.
  pos_pattern_rom u_rom (
    .i_code    (r_code),
    .o_pattern (w_pattern)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= PG_IDLE;
      r_cnt   <= 8'd0;
      r_code  <= 2'd0;
      r_seg   <= 7'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_code  <= w_code_nxt;
      r_seg   <= w_seg_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_code_nxt  = r_code;
    case (r_state)
      PG_IDLE: begin
        if (start) begin
          w_code_nxt  = pos_in;
          w_state_nxt = PG_PRE;
          w_cnt_nxt   = 8'd0;
        end
      end
      PG_PRE: begin
        if (r_cnt == HOLD_LAST) begin
          w_state_nxt = PG_DRIVE;
          w_cnt_nxt   = 8'd0;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      PG_DRIVE: begin
        if (r_cnt == HOLD_LAST) begin
          w_state_nxt = PG_GUARD;
          w_cnt_nxt   = 8'd0;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      PG_GUARD: begin
        if (r_cnt == GUARD_LAST) begin
          w_state_nxt = PG_DONE;
          w_cnt_nxt   = 8'd0;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      PG_DONE: begin
        w_state_nxt = PG_IDLE;
        w_cnt_nxt   = 8'd0;
      end
      default: begin
        w_state_nxt = PG_IDLE;
        w_cnt_nxt   = 8'd0;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with r_state.
  always_comb begin
    w_busy_nxt = (w_state_nxt == PG_PRE) || (w_state_nxt == PG_DRIVE) ||
                 (w_state_nxt == PG_GUARD);
    w_done_nxt = (w_state_nxt == PG_DONE);
    w_seg_nxt  = (w_state_nxt == PG_DRIVE) ? w_pattern : 7'd0;
  end

  assign {a, b, c, d, e, f, g} = r_seg;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_pos_pattern_gen.sv
// Self-checking bench for pos_pattern_gen: table-driven frames plus directed
// sequences for reset mid-frame, continuous start, and HOLD=GUARD=1.
module tb_pos_pattern_gen;

  localparam int H0 = 4;
  localparam int G0 = 2;

  logic       clk;
  logic       rst_n;
  logic       start0, start1;
  logic [1:0] pos0, pos1;
  logic [6:0] seg0, seg1;
  logic       busy0, done0, busy1, done1;

  int n_cmp;
  int n_bad;

  logic [1:0] exp_q[$];

  typedef struct {
    logic [1:0] pos;
    logic [6:0] pat;
  } vec_t;

  vec_t vecs[4];

  pos_pattern_gen #(.HOLD(H0), .GUARD(G0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .pos_in(pos0),
    .a(seg0[6]), .b(seg0[5]), .c(seg0[4]), .d(seg0[3]),
    .e(seg0[2]), .f(seg0[1]), .g(seg0[0]),
    .busy(busy0), .done(done0)
  );

  pos_pattern_gen #(.HOLD(1), .GUARD(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .pos_in(pos1),
    .a(seg1[6]), .b(seg1[5]), .c(seg1[4]), .d(seg1[3]),
    .e(seg1[2]), .f(seg1[1]), .g(seg1[0]),
    .busy(busy1), .done(done1)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver / check tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got busy/done/seg=%b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Independent receive-side model: maps a seen pattern back to its code.
  function automatic logic [2:0] rx_decode(input logic [6:0] p);
    case (p)
      7'b1110010: return 3'b100;
      7'b0110000: return 3'b101;
      7'b1101101: return 3'b110;
      7'b1111001: return 3'b111;
      default:    return 3'b000;
    endcase
  endfunction

  // One frame on dut0; k counts edges after the accepting edge.
  task automatic run_frame(input string name, input logic [1:0] p, input logic [6:0] pat);
    logic [8:0] exp;
    logic [6:0] seen;
    seen   = 7'd0;
    start0 = 1'b1;
    pos0   = p;
    tick();
    start0 = 1'b0;
    pos0   = ~p;
    for (int k = 0; k <= 2*H0 + G0 + 1; k++) begin
      exp[8] = (k < 2*H0 + G0);
      exp[7] = (k == 2*H0 + G0);
      exp[6:0] = (k >= H0 && k < 2*H0) ? pat : 7'd0;
      chk(name, {busy0, done0, seg0}, exp);
      if (k == H0) seen = seg0;
      if (k == H0 + 1) start0 = 1'b1;
      if (k == 2*H0 + G0) start0 = 1'b0;
      if (k < 2*H0 + G0 + 1) tick();
    end
    n_cmp++;
    if (rx_decode(seen) !== {1'b1, p}) begin
      n_bad++;
      $display("FAIL %s loopback: decoded %b expected %b", name, rx_decode(seen), {1'b1, p});
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_bad  = 0;
    rst_n  = 1'b0;
    start0 = 1'b0;
    start1 = 1'b0;
    pos0   = 2'd0;
    pos1   = 2'd0;
    vecs[0] = '{pos: 2'd0, pat: 7'b1110010};
    vecs[1] = '{pos: 2'd1, pat: 7'b0110000};
    vecs[2] = '{pos: 2'd2, pat: 7'b1101101};
    vecs[3] = '{pos: 2'd3, pat: 7'b1111001};

    #23;
    chk("reset0", {busy0, done0, seg0}, 9'd0);
    chk("reset1", {busy1, done1, seg1}, 9'd0);
    rst_n = 1'b1;
    tick();
    tick();
    chk("idle0", {busy0, done0, seg0}, 9'd0);

    // Table-driven frames (start re-asserted mid-frame must be ignored).
    for (int i = 0; i < 4; i++) begin
      run_frame($sformatf("frame_pos%0d", vecs[i].pos), vecs[i].pos, vecs[i].pat);
      tick();
    end

    // Reset mid-DRIVE with pos=2.
    start0 = 1'b1;
    pos0   = 2'd2;
    tick();
    start0 = 1'b0;
    for (int k = 0; k < H0 + 1; k++) tick();
    chk("pre_reset_drive", {busy0, done0, seg0}, {2'b10, 7'b1101101});
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", {busy0, done0, seg0}, 9'd0);
    #1;
    rst_n = 1'b1;
    tick();
    chk("after_reset_idle", {busy0, done0, seg0}, 9'd0);
    run_frame("after_reset_frame", 2'd1, 7'b0110000);
    tick();

    // Continuous start with pos_in toggling; scoreboard of accepted codes.
    begin
      logic       prev_busy, prev_done;
      logic [1:0] drv;
      int         low_run, frames, seen_pat;
      prev_busy = 1'b0;
      prev_done = 1'b0;
      low_run   = 0;
      frames    = 0;
      seen_pat  = 0;
      start0    = 1'b1;
      for (int cyc = 0; cyc < 5 * (2*H0 + G0 + 2) && frames < 4; cyc++) begin
        drv  = 2'(cyc * 3 + 1);
        pos0 = drv;
        tick();
        if (busy0 && !prev_busy) begin
          exp_q.push_back(drv);
          if (frames > 0) begin
            n_cmp++;
            if (low_run != 2) begin
              n_bad++;
              $display("FAIL b2b_gap: busy low %0d cycles expected 2", low_run);
            end
          end
          frames++;
          seen_pat = 0;
        end
        if (!busy0) low_run++; else low_run = 0;
        if (seg0 != 7'd0 && seen_pat == 0) begin
          seen_pat = 1;
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL b2b_code: pattern %b with no accepted code", seg0);
          end else begin
            logic [1:0] ec;
            ec = exp_q.pop_front();
            if (rx_decode(seg0) !== {1'b1, ec}) begin
              n_bad++;
              $display("FAIL b2b_code: pattern %b expected code %0d", seg0, ec);
            end
          end
        end
        if (prev_done) begin
          chk("b2b_after_done", {busy0, done0, seg0}, 9'd0);
        end
        prev_busy = busy0;
        prev_done = done0;
      end
      start0 = 1'b0;
      n_cmp++;
      if (frames < 4) begin
        n_bad++;
        $display("FAIL b2b_frames: saw %0d frames expected 4", frames);
      end
    end

    // HOLD=1, GUARD=1 on dut1, pos=3.
    start1 = 1'b1;
    pos1   = 2'd3;
    tick();
    start1 = 1'b0;
    pos1   = 2'd0;
    chk("h1_pre",   {busy1, done1, seg1}, {2'b10, 7'd0});
    tick();
    chk("h1_drive", {busy1, done1, seg1}, {2'b10, 7'b1111001});
    tick();
    chk("h1_guard", {busy1, done1, seg1}, {2'b10, 7'd0});
    tick();
    chk("h1_done",  {busy1, done1, seg1}, {2'b01, 7'd0});
    tick();
    chk("h1_idle",  {busy1, done1, seg1}, 9'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
